// File: rtl/mips_multiciclo_core.sv
// mips_multiciclo_core: multi-cycle MIPS subset (R-type, lw, sw, beq, addi, halt) with a shared req/ready memory port.
// Define BNE_EN to also decode bne (opcode 000101); otherwise that opcode is illegal.
module mips_multiciclo_core #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 8,
    parameter int REG_COUNT = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [PC_W-1:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [PC_W-1:0]   pc_out,
    output logic              halted,
    output logic              illegal
);
    localparam int RW = $clog2(REG_COUNT);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t            state, state_nx;
    logic [PC_W-1:0]   pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a, b, alu_out, mdr;
    logic [DATA_W-1:0] regs [REG_COUNT];

    logic [5:0]        op, funct;
    logic [RW-1:0]     rs_i, rt_i, rd_i, wa;
    logic [DATA_W-1:0] sext_imm, alu_b, sum, alu_res, wd;
    logic [PC_W-1:0]   bt;
    logic              is_r, r_ok, is_lw, is_sw, is_addi, is_beq, is_bne, is_halt, legal, taken, slt;

    assign op       = ir[31:26];
    assign funct    = ir[5:0];
    assign rs_i     = ir[21 +: RW];
    assign rt_i     = ir[16 +: RW];
    assign rd_i     = ir[11 +: RW];
    assign sext_imm = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    assign bt       = pc + PC_W'(sext_imm << 2);

    assign is_r    = op == 6'b000000;
    assign r_ok    = funct == 6'b100000 || funct == 6'b100010 || funct == 6'b100100 ||
                     funct == 6'b100101 || funct == 6'b101010;
    assign is_lw   = op == 6'b100011;
    assign is_sw   = op == 6'b101011;
    assign is_addi = op == 6'b001000;
    assign is_beq  = op == 6'b000100;
    assign is_halt = op == 6'b111111;
`ifdef BNE_EN
    assign is_bne  = op == 6'b000101;
`else
    assign is_bne  = 1'b0;
`endif
    // Bad R-type funct is caught in DECODE so every illegal instruction costs two cycles
    assign legal = (is_r && r_ok) || is_lw || is_sw || is_addi || is_beq || is_bne || is_halt;
    assign taken = (is_beq && a == b) || (is_bne && a != b);

    assign alu_b   = is_r ? b : sext_imm;
    assign sum     = a + alu_b;
    assign slt     = $signed(a) < $signed(b);
    assign alu_res = !is_r                 ? sum :
                     funct == 6'b100010    ? a - b :
                     funct == 6'b100100    ? a & b :
                     funct == 6'b100101    ? a | b :
                     funct == 6'b101010    ? DATA_W'(slt) : sum;

    assign wa = is_r ? rd_i : rt_i;
    assign wd = is_lw ? mdr : alu_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  state_nx = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_nx = is_halt ? S_HALT : !legal ? S_FETCH : S_EXEC;
            S_EXEC:   state_nx = (is_lw || is_sw) ? S_MEM : (is_beq || is_bne) ? S_FETCH : S_WB;
            S_MEM:    state_nx = !mem_ready ? S_MEM : is_sw ? S_FETCH : S_WB;
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_HALT;
        endcase
    end

    // Request is gated by reset directly so an access in flight is dropped at once
    always_comb begin
        mem_req   = !reset && (state == S_FETCH || state == S_MEM);
        mem_we    = !reset && state == S_MEM && is_sw;
        mem_addr  = state == S_MEM ? alu_out[PC_W-1:0] : pc;
        mem_wdata = (state == S_MEM && is_sw) ? b : '0;
        halted    = state == S_HALT;
        illegal   = state == S_DECODE && !legal;
        pc_out    = pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata[31:0];
                    pc <= pc + PC_W'(4);
                end
                S_DECODE: begin
                    a <= rs_i == '0 ? '0 : regs[rs_i];
                    b <= rt_i == '0 ? '0 : regs[rt_i];
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (taken) pc <= bt;
                end
                S_MEM: if (mem_ready && !is_sw) mdr <= mem_rdata;
                S_WB: if (wa != '0) regs[wa] <= wd;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multiciclo_core.sv
// tb_mips_multiciclo_core: directed programs; every completed memory access is checked against a scoreboard.
module tb_mips_multiciclo_core;
    logic        clk = 0, reset = 1;
    logic        mem_req, mem_we, mem_ready, halted, illegal;
    logic [7:0]  mem_addr, pc_out;
    logic [31:0] mem_wdata, mem_rdata;

    mips_multiciclo_core dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100, F_OR = 6'b100101, F_SLT = 6'b101010;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          len;
        int          gap;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:63];
    logic [5:0]  pi;
    int          fwait = 0, dwait = 0, wcnt = 0, cyc = 0, last = 0, ill_cnt = 0;
    int          checks = 0, passed = 0;
    logic        stray = 0;

    assign mem_ready = stray || (mem_req && wcnt >= (mem_addr[7] ? dwait : fwait));
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        cyc++;
        if (reset) wcnt <= 0;
        else if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (!reset && mem_req && mem_we && mem_ready) mem[mem_addr[7:2]] = mem_wdata;
    end

    always @(negedge clk) if (!reset && illegal) ill_cnt++;

    logic [7:0]  a0;
    logic [31:0] w0;
    logic        we0, bad;
    int          hold = 0;
    exp_t        e;
    always @(negedge clk) begin
        if (reset) begin
            hold = 0;
            bad = 0;
        end else if (mem_req) begin
            if (hold == 0) begin
                a0 = mem_addr; w0 = mem_wdata; we0 = mem_we;
            end else if (mem_addr !== a0 || mem_we !== we0 || mem_wdata !== w0) bad = 1;
            hold++;
            if (mem_ready) begin
                checks++;
                if (sb.size() == 0)
                    $display("FAIL access: unexpected we=%0b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
                else begin
                    e = sb.pop_front();
                    if (mem_we === e.we && mem_addr === e.addr && (!e.we || mem_wdata === e.wdata) &&
                        hold == e.len && (e.gap < 0 || cyc - last == e.gap) && !bad) passed++;
                    else
                        $display("FAIL access: got we=%0b addr=%h wdata=%h len=%0d gap=%0d unstable=%0b, expected we=%0b addr=%h wdata=%h len=%0d gap=%0d",
                                 mem_we, mem_addr, mem_wdata, hold, cyc - last, bad, e.we, e.addr, e.wdata, e.len, e.gap);
                end
                last = cyc;
                hold = 0;
                bad = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    endtask

    task automatic ex(input bit we, input int a, input logic [31:0] wd, input int len, input int gap);
        exp_t x;
        x.we = we; x.addr = a[7:0]; x.wdata = wd; x.len = len; x.gap = gap;
        sb.push_back(x);
    endtask
    task automatic f(input int a, input int gap);                     ex(0, a, 0, fwait + 1, gap); endtask
    task automatic dw(input int a, input logic [31:0] wd, input int gap); ex(1, a, wd, dwait + 1, gap); endtask
    task automatic dr(input int a, input int gap);                    ex(0, a, 0, dwait + 1, gap); endtask

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] rr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic put(input logic [31:0] w);
        mem[pi] = w;
        pi++;
    endtask

    task automatic release_reset;
        @(posedge clk);
        #2 reset = 0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 0;
        pi = 0;
        put(ri(ADDI, 0, 1, 16'd5));
        put(ri(ADDI, 0, 2, 16'd7));
        put(rr(1, 2, 3, F_ADD));
        put(HALT);
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_pc", pc_out, 0);
        f(0, -1); f(4, 4); f(8, 4); f(12, 4);
        release_reset();
        n = 0;
        while (!halted && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("halt_cycles", n, 14);
        chk("halted", halted, 1);
        repeat (3) @(negedge clk);
        chk("halt_req", mem_req, 0);
        chk("halt_pc", pc_out, 8'h10);
        chk("sb_a_empty", sb.size(), 0);

        // Program B: data accesses have two wait cycles
        @(negedge clk);
        reset = 1;
        fwait = 0; dwait = 2; ill_cnt = 0;
        pi = 0;
        put(ri(ADDI, 0, 1, 16'd5));       put(ri(ADDI, 0, 2, 16'd7));      put(rr(1, 2, 3, F_ADD));
        put(ri(SW, 0, 3, 16'h80));        put(ri(LW, 0, 4, 16'h80));       put(ri(SW, 0, 4, 16'h84));
        put(ri(BEQ, 1, 2, 16'd5));        put(ri(ADDI, 0, 1, 16'hFFFF));   put(ri(ADDI, 0, 2, 16'd1));
        put(rr(1, 2, 5, F_SUB));          put(ri(SW, 0, 5, 16'h88));
        put(rr(1, 2, 5, F_AND));          put(ri(SW, 0, 5, 16'h8C));
        put(rr(1, 2, 5, F_OR));           put(ri(SW, 0, 5, 16'h90));
        put(rr(1, 2, 6, F_SLT));          put(ri(SW, 0, 6, 16'h94));
        put(rr(2, 1, 6, F_SLT));          put(ri(SW, 0, 6, 16'h98));
        put(ri(ADDI, 0, 7, 16'd3));       put(ri(ADDI, 0, 0, 16'd9));      put(rr(0, 0, 7, F_ADD));
        put(ri(SW, 0, 7, 16'h9C));        put(32'hF800_0000);              put(rr(1, 2, 5, 6'h3F));
        put(ri(SW, 0, 5, 16'hA0));        put(ri(BEQ, 1, 1, 16'hFFFF));
        f(8'h00, -1); f(8'h04, 4); f(8'h08, 4); f(8'h0C, 4);
        dw(8'h80, 12, 5); f(8'h10, 1);
        dr(8'h80, 5); f(8'h14, 2);
        dw(8'h84, 12, 5); f(8'h18, 1);
        f(8'h1C, 3); f(8'h20, 4); f(8'h24, 4); f(8'h28, 4);
        dw(8'h88, 32'hFFFF_FFFE, 5); f(8'h2C, 1); f(8'h30, 4);
        dw(8'h8C, 32'h1, 5); f(8'h34, 1); f(8'h38, 4);
        dw(8'h90, 32'hFFFF_FFFF, 5); f(8'h3C, 1); f(8'h40, 4);
        dw(8'h94, 32'h1, 5); f(8'h44, 1); f(8'h48, 4);
        dw(8'h98, 32'h0, 5); f(8'h4C, 1); f(8'h50, 4); f(8'h54, 4); f(8'h58, 4);
        dw(8'h9C, 32'h0, 5); f(8'h5C, 1); f(8'h60, 2); f(8'h64, 2);
        dw(8'hA0, 32'hFFFF_FFFF, 5); f(8'h68, 1);
        f(8'h68, 3); f(8'h68, 3); f(8'h68, 3);
        release_reset();
        drain("sb_b_drain");
        chk("illegal_b", ill_cnt, 2);

        // Stall the next fetch of the beq loop and reset in the middle of it
        fwait = 3;
        for (int i = 0; i < 50 && !(mem_req && !mem_ready); i++) @(negedge clk);
        chk("stall_seen", mem_req && !mem_ready, 1);
        reset = 1;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_pc", pc_out, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_halted", halted, 0);

        // Program C: registers must be zero again; stray ready while idle must be ignored
        @(negedge clk);
        fwait = 0; dwait = 0; ill_cnt = 0; stray = 1;
        pi = 0;
        put(ri(SW, 0, 1, 16'hA4));  put(ri(SW, 0, 5, 16'hA8));  put(ri(ADDI, 0, 1, 16'd1));
        put(ri(BNE, 1, 2, 16'd2));  put(ri(SW, 0, 1, 16'hAC));  put(HALT);
        put(ri(SW, 0, 1, 16'hB0));  put(HALT);
        f(8'h00, -1); dw(8'hA4, 0, 3); f(8'h04, 1); dw(8'hA8, 0, 3); f(8'h08, 1); f(8'h0C, 4);
`ifdef BNE_EN
        f(8'h18, 3); dw(8'hB0, 1, 3); f(8'h1C, 1);
`else
        f(8'h10, 2); dw(8'hAC, 1, 3); f(8'h14, 1);
`endif
        release_reset();
        for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
        chk("halted_c", halted, 1);
        chk("sb_c_empty", sb.size(), 0);
`ifdef BNE_EN
        chk("illegal_c", ill_cnt, 0);
        chk("halt_pc_c", pc_out, 8'h20);
`else
        chk("illegal_c", ill_cnt, 1);
        chk("halt_pc_c", pc_out, 8'h18);
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
